// File: rtl/rv32i_types.sv
// Shared types for the memory-side path: cacheline/word types and the arbiter state.
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] llc_cacheline;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } arb_state_t;

    // Request/grant vector bit positions and last_grant encoding
    localparam int unsigned REQ_I = 0;
    localparam int unsigned REQ_D = 1;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin tie-break: a lone requester always wins, a tie goes to the
// side that did not win last. last_grant only moves when advance is high.
module rr_grant2
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GNT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset to D so that I wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_D;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[REQ_D] ? GNT_D : GNT_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates Icache line reads and Dcache line reads/writebacks onto a single
// cacheline adaptor; one transaction at a time, downstream driven from latched copies.
module cache_arbiter
    import rv32i_types::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic         i_pmem_read,
    input  rv32i_word    i_pmem_address,
    output llc_cacheline i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  rv32i_word    d_pmem_address,
    input  llc_cacheline d_pmem_wdata,
    output llc_cacheline d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output rv32i_word    pmem_address,
    output llc_cacheline pmem_wdata,
    input  llc_cacheline pmem_rdata,
    input  logic         pmem_resp
);

    arb_state_t   state;
    arb_state_t   state_next;
    rv32i_word    hold_addr;
    llc_cacheline hold_wdata;
    logic         hold_write;
    logic [1:0]   req;
    logic [1:0]   gnt;
    logic         idle;

    assign idle           = (state == IDLE);
    assign req[REQ_I]     = i_pmem_read;
    assign req[REQ_D]     = d_pmem_read | d_pmem_write;

    rr_grant2 u_rr_grant2 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (idle),
        .gnt     (gnt)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (gnt[REQ_I])      state_next = I_BUSY;
                else if (gnt[REQ_D]) state_next = D_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holding registers load only on a grant, so requester changes while busy are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_write <= 1'b0;
        end else if (idle && gnt[REQ_I]) begin
            hold_addr  <= i_pmem_address;
            hold_wdata <= '0;
            hold_write <= 1'b0;
        end else if (idle && gnt[REQ_D]) begin
            hold_addr  <= d_pmem_address;
            hold_wdata <= d_pmem_wdata;
            hold_write <= d_pmem_write;
        end
    end

    assign pmem_read    = !idle && !hold_write;
    assign pmem_write   = !idle && hold_write;
    assign pmem_address = hold_addr;
    assign pmem_wdata   = hold_wdata;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign i_pmem_resp  = (state == I_BUSY) && pmem_resp;
    assign d_pmem_resp  = (state == D_BUSY) && pmem_resp;

endmodule
